// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: default amplitude, dibit/phase types and Gray lookups
// used by the mapper and by the decoder's slicer.
package qpsk_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam logic signed [SAMPLE_W-1:0] AMP_DEFAULT = 8'sd90;

   typedef logic [1:0] dibit_t;
   typedef logic [1:0] phase_t;

   typedef enum logic {
      ST_IDLE,
      ST_PLAY
   } state_t;

   // Quadrant advance carried by a dibit in differential mode.
   function automatic phase_t diff_increment(input dibit_t d);
      case (d)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Absolute phase to the Gray dibit whose direct mapping gives that constellation point.
   function automatic dibit_t phase_to_dibit(input phase_t p);
      case (p)
         2'd0:    return 2'b00;
         2'd1:    return 2'b10;
         2'd2:    return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

endpackage

// File: rtl/qpsk_level_map.sv
// Combinational Gray dibit to signed I/Q level mapping: bit 0 -> +AMP, bit 1 -> -AMP.
module qpsk_level_map
   import qpsk_pkg::*;
#(
   parameter logic signed [SAMPLE_W-1:0] AMP = AMP_DEFAULT
)(
   input  logic [1:0]                 dibit,
   output logic signed [SAMPLE_W-1:0] level_i_c,
   output logic signed [SAMPLE_W-1:0] level_q_c
);

   localparam logic signed [SAMPLE_W-1:0] NEG_AMP = -AMP;

   assign level_i_c = dibit[1] ? NEG_AMP : AMP;
   assign level_q_c = dibit[0] ? NEG_AMP : AMP;

endmodule

// File: rtl/qpsk_mapper.sv
// Serial bit stream to held QPSK I/Q symbols, SPS samples per symbol.
// Define QPSK_DIFF_EN for differential (phase-increment) encoding.
module qpsk_mapper
   import qpsk_pkg::*;
#(
   parameter int unsigned                SPS = 8,
   parameter logic signed [SAMPLE_W-1:0] AMP = AMP_DEFAULT
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   output logic                       bit_ready,
   output logic signed [SAMPLE_W-1:0] dataI,
   output logic signed [SAMPLE_W-1:0] dataQ,
   output logic                       out_valid,
   output logic                       sym_start,
   output logic [1:0]                 dibit_out,
   output logic                       underrun
);

   localparam int unsigned      CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       half_valid_q, half_valid_d;
   logic                       half_bit_q, half_bit_d;
   dibit_t                     pending_q, pending_d;
   logic                       pending_full_q, pending_full_d;
   logic                       bit_ready_d;
   logic signed [SAMPLE_W-1:0] data_i_d, data_q_d;
   logic                       out_valid_d, sym_start_d, underrun_d;
   dibit_t                     dibit_out_d;

   logic                       accept_c, pair_done_c, load_c, bypass_c;
   dibit_t                     assembled_c, load_dibit_c, map_dibit_c;
   logic signed [SAMPLE_W-1:0] map_i_c, map_q_c;

   assign accept_c    = bit_valid && bit_ready;
   assign pair_done_c = accept_c && half_valid_q;
   assign assembled_c = {half_bit_q, bit_in};
   // A load takes the pending dibit when present, otherwise the pair completing this cycle.
   assign load_dibit_c = pending_full_q ? pending_q : assembled_c;

`ifdef QPSK_DIFF_EN
   phase_t phase_q, phase_d, phase_next_c;
   assign phase_next_c = phase_q + diff_increment(load_dibit_c);
   assign map_dibit_c  = phase_to_dibit(phase_next_c);
`else
   assign map_dibit_c  = load_dibit_c;
`endif

   qpsk_level_map #(.AMP(AMP)) u_level_map (
      .dibit     (map_dibit_c),
      .level_i_c (map_i_c),
      .level_q_c (map_q_c)
   );

   // Next-state, assembler, pending slot and output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      half_valid_d   = half_valid_q;
      half_bit_d     = half_bit_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      data_i_d       = dataI;
      data_q_d       = dataQ;
      out_valid_d    = out_valid;
      sym_start_d    = 1'b0;
      dibit_out_d    = dibit_out;
      underrun_d     = underrun;
      load_c         = 1'b0;
      bypass_c       = 1'b0;
`ifdef QPSK_DIFF_EN
      phase_d        = phase_q;
`endif

      if (accept_c) begin
         half_valid_d = !half_valid_q;
         if (!half_valid_q) half_bit_d = bit_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (pending_full_q) begin
               load_c  = 1'b1;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (pending_full_q) begin
               load_c = 1'b1;
            end else if (pair_done_c) begin
               // Short symbols: the pair completes on the last sample, so forward it directly.
               load_c   = 1'b1;
               bypass_c = 1'b1;
            end else begin
               underrun_d  = 1'b1;
               state_d     = ST_IDLE;
               cnt_d       = '0;
               data_i_d    = '0;
               data_q_d    = '0;
               out_valid_d = 1'b0;
               dibit_out_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pair_done_c && !bypass_c) begin
         pending_d      = assembled_c;
         pending_full_d = 1'b1;
      end

      if (load_c) begin
         if (!bypass_c) pending_full_d = 1'b0;
         data_i_d    = map_i_c;
         data_q_d    = map_q_c;
         dibit_out_d = load_dibit_c;
         out_valid_d = 1'b1;
         sym_start_d = 1'b1;
         cnt_d       = '0;
`ifdef QPSK_DIFF_EN
         phase_d     = phase_next_c;
`endif
      end

      bit_ready_d = !pending_full_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         half_valid_q   <= 1'b0;
         half_bit_q     <= 1'b0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         bit_ready      <= 1'b1;
         dataI          <= '0;
         dataQ          <= '0;
         out_valid      <= 1'b0;
         sym_start      <= 1'b0;
         dibit_out      <= '0;
         underrun       <= 1'b0;
`ifdef QPSK_DIFF_EN
         phase_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         half_valid_q   <= half_valid_d;
         half_bit_q     <= half_bit_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         bit_ready      <= bit_ready_d;
         dataI          <= data_i_d;
         dataQ          <= data_q_d;
         out_valid      <= out_valid_d;
         sym_start      <= sym_start_d;
         dibit_out      <= dibit_out_d;
         underrun       <= underrun_d;
`ifdef QPSK_DIFF_EN
         phase_q        <= phase_d;
`endif
      end
   end

endmodule

// File: tb/tb_qpsk_mapper.sv
// Self-checking bench for qpsk_mapper (SPS=8 and SPS=2 instances) against a queue-based symbol model.
module tb_qpsk_mapper;
   import qpsk_pkg::*;

   localparam logic signed [7:0] AMP = 8'sd90;

   logic clk;
   logic rst8, rst2, bit_in, bit_valid;
   logic rdy8, ov8, ss8, und8, rdy2, ov2, ss2, und2;
   logic signed [7:0] di8, dq8, di2, dq2;
   logic [1:0] dib8, dib2;

   qpsk_mapper #(.SPS(8), .AMP(AMP)) dut8 (
      .clk(clk), .rst(rst8), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy8),
      .dataI(di8), .dataQ(dq8), .out_valid(ov8), .sym_start(ss8), .dibit_out(dib8), .underrun(und8));

   qpsk_mapper #(.SPS(2), .AMP(AMP)) dut2 (
      .clk(clk), .rst(rst2), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy2),
      .dataI(di2), .dataQ(dq2), .out_valid(ov2), .sym_start(ss2), .dibit_out(dib2), .underrun(und2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit sel;
   logic o_ov, o_ss, o_und, o_rdy;
   logic signed [7:0] o_i, o_q;
   logic [1:0] o_dib;
   assign o_ov  = sel ? ov2  : ov8;
   assign o_ss  = sel ? ss2  : ss8;
   assign o_und = sel ? und2 : und8;
   assign o_rdy = sel ? rdy2 : rdy8;
   assign o_i   = sel ? di2  : di8;
   assign o_q   = sel ? dq2  : dq8;
   assign o_dib = sel ? dib2 : dib8;

   int checks = 0;
   int failures = 0;

   logic [1:0]        exp_q[$];
   logic              half_v, half_b, prev_ov, und_m;
   int                pairs, syms, samp;
   logic [1:0]        phase_m;
   logic signed [7:0] cur_i, cur_q;
   logic signed [7:0] ei_tab [4];
   logic signed [7:0] eq_tab [4];

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int quad_step(input logic [1:0] d);
      case (d)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      half_v = 1'b0; half_b = 1'b0; prev_ov = 1'b0; und_m = 1'b0;
      pairs = 0; syms = 0; samp = 0; phase_m = 2'd0;
      cur_i = 8'sd0; cur_q = 8'sd0;
   endtask

   task automatic check_reset();
      check("rst_dataI", o_i, 0);
      check("rst_dataQ", o_q, 0);
      check("rst_out_valid", o_ov, 0);
      check("rst_sym_start", o_ss, 0);
      check("rst_dibit_out", o_dib, 0);
      check("rst_underrun", o_und, 0);
      check("rst_bit_ready", o_rdy, 1);
   endtask

   // Compare the visible sample against the symbol model.
   task automatic observe();
      int sps;
      logic [1:0] d;
      logic signed [7:0] ei, eq;
      sps = sel ? 2 : 8;
      if (o_ss) begin
         if (prev_ov) check("sym_len_before_next", samp, sps);
         check("dibit_queued", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) d = exp_q.pop_front();
         else d = 2'b00;
         syms++;
`ifdef QPSK_DIFF_EN
         phase_m = phase_m + 2'(quad_step(d));
         ei = (phase_m == 2'd1 || phase_m == 2'd2) ? -AMP : AMP;
         eq = (phase_m >= 2'd2) ? -AMP : AMP;
`else
         ei = d[1] ? -AMP : AMP;
         eq = d[0] ? -AMP : AMP;
`endif
         check("sym_dataI", o_i, ei);
         check("sym_dataQ", o_q, eq);
         check("sym_dibit_out", o_dib, d);
         check("sym_out_valid", o_ov, 1);
         cur_i = ei; cur_q = eq; samp = 1;
      end else if (o_ov) begin
         check("sample_within_symbol", samp < sps, 1);
         check("hold_dataI", o_i, cur_i);
         check("hold_dataQ", o_q, cur_q);
         samp++;
      end else begin
         if (prev_ov) begin
            check("sym_len_at_end", samp, sps);
            und_m = 1'b1;
         end
         check("idle_dataI", o_i, 0);
         check("idle_dataQ", o_q, 0);
         check("idle_dibit_out", o_dib, 0);
      end
      check("underrun", o_und, und_m);
      check("bit_ready", o_rdy, pairs == syms);
      prev_ov = o_ov;
   endtask

   // One clock: track accepted bits into dibits, then check the outputs.
   task automatic step();
      logic r, acc, b;
      r   = sel ? rst2 : rst8;
      acc = bit_valid && o_rdy;
      b   = bit_in;
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
         check_reset();
         return;
      end
      if (acc) begin
         if (half_v) begin
            exp_q.push_back({half_b, b});
            pairs++;
            half_v = 1'b0;
         end else begin
            half_v = 1'b1;
            half_b = b;
         end
      end
      observe();
   endtask

   task automatic reset8();
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
   endtask

   task automatic stream8(input logic [7:0] bits);
      int idx, nsym, first, last, nov;
      logic acc;
      idx = 0; nsym = 0; first = -1; last = -1; nov = 0;
      for (int c = 0; c < 60; c++) begin
         bit_valid = (idx < 8);
         bit_in    = (idx < 8) ? bits[7 - idx] : 1'b0;
         acc       = bit_valid && o_rdy;
         step();
         if (acc) idx++;
         if (o_ov) begin
            nov++;
            if (first < 0) first = c;
            last = c;
         end
         if (o_ss) begin
            if (nsym < 4) begin
               check("stream_sym_I", o_i, ei_tab[nsym]);
               check("stream_sym_Q", o_q, eq_tab[nsym]);
            end
            nsym++;
         end
      end
      bit_valid = 1'b0;
      check("stream_symbols", nsym, 4);
      check("stream_valid_cycles", nov, 32);
      check("stream_no_gap", last - first + 1, 32);
   endtask

   initial begin
      int gaps;
      logic seen;
      sel = 1'b0; rst8 = 1'b1; rst2 = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
      model_reset();
      step();
      step();
      rst8 = 1'b0;

      // Pair 0,1 from reset: one symbol, then underrun.
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
      bit_in = 1'b1;
      step();
      bit_valid = 1'b0;
      check("t1_no_out_yet", o_ov, 0);
      check("t1_ready_low", o_rdy, 0);
      step();
      check("t1_sym_start", o_ss, 1);
`ifdef QPSK_DIFF_EN
      check("t1_dataI", o_i, -90);
      check("t1_dataQ", o_q, 90);
`else
      check("t1_dataI", o_i, 90);
      check("t1_dataQ", o_q, -90);
`endif
      check("t1_dibit", o_dib, 2'b01);
      for (int k = 1; k < 8; k++) begin
         step();
         check("t1_hold_valid", o_ov, 1);
         check("t1_no_restart", o_ss, 0);
      end
      step();
      check("t1_end_valid", o_ov, 0);
      check("t1_underrun", o_und, 1);
      check("t1_zero_I", o_i, 0);

      // Continuous stream 00,11,10,01.
      reset8();
`ifdef QPSK_DIFF_EN
      ei_tab = '{8'sd90, -8'sd90, -8'sd90, -8'sd90};
      eq_tab = '{8'sd90, -8'sd90, 8'sd90, -8'sd90};
`else
      ei_tab = '{8'sd90, -8'sd90, -8'sd90, 8'sd90};
      eq_tab = '{8'sd90, -8'sd90, 8'sd90, -8'sd90};
`endif
      stream8(8'b00111001);

      // Half dibit held through a 20-cycle stall.
      reset8();
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
      bit_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         check("t3_gap_quiet", o_ov, 0);
      end
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
      bit_valid = 1'b0;
      check("t3_wait", o_ov, 0);
      step();
      check("t3_start", o_ss, 1);
`ifdef QPSK_DIFF_EN
      check("t3_dataI", o_i, 90);
      check("t3_dataQ", o_q, -90);
`else
      check("t3_dataI", o_i, -90);
      check("t3_dataQ", o_q, 90);
`endif
      repeat (9) step();

      // Reset at sample 3 with a half dibit held, then a fresh 0,0 pair.
      reset8();
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
      step();
      bit_valid = 1'b0;
      step();
      check("t4_sample0", o_ss, 1);
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
      bit_valid = 1'b0;
      step();
      step();
      check("t4_sample3_live", o_ov, 1);
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
      step();
      bit_valid = 1'b0;
      step();
      check("t4_fresh_start", o_ss, 1);
      check("t4_fresh_I", o_i, 90);
      check("t4_fresh_Q", o_q, 90);
      repeat (9) step();

`ifdef QPSK_DIFF_EN
      // Differential: four 01 dibits walk the phase 1,2,3,0.
      reset8();
      ei_tab = '{-8'sd90, -8'sd90, 8'sd90, 8'sd90};
      eq_tab = '{8'sd90, -8'sd90, -8'sd90, 8'sd90};
      stream8(8'b01010101);
`endif

      // Random bursty traffic checked by the model.
      reset8();
      for (int c = 0; c < 400; c++) begin
         bit_valid = ($urandom_range(0, 9) < 7);
         bit_in    = 1'($urandom_range(0, 1));
         step();
      end
      bit_valid = 1'b0;
      repeat (12) step();

      // SPS=2 with a bit every clock must never underrun.
      rst8 = 1'b1;
      sel = 1'b1;
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      bit_valid = 1'b1;
      gaps = 0;
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         bit_in = 1'($urandom_range(0, 1));
         step();
         if (o_ov) seen = 1'b1;
         else if (seen) gaps++;
      end
      bit_valid = 1'b0;
      check("sps2_started", seen, 1);
      check("sps2_gaps", gaps, 0);
      check("sps2_underrun", o_und, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qpsk_mapper.md
Name: qpsk_mapper

Overview:
- Upstream stage of the QPSK decoder, fed by the m-sequence generator's serial bit stream.
- Pairs incoming bits into dibits: first bit goes to I, second bit goes to Q.
- Maps each dibit to signed 8-bit I/Q levels and holds every symbol for SPS clocks.
- Provides the sample-rate I/Q stream the decoder consumes; also exports the transmitted dibit for loopback comparison.

Parameters:
- SPS, 8, samples per symbol; legal range 2..64.
- AMP, 8'sd90, magnitude of each I/Q level in two's complement; legal range 1..127.
- CNT_W, $clog2(SPS), width of the sample counter (derived; not for override).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  mapper accepts bit_in this cycle.
- dataI  out  8  signed I sample.
- dataQ  out  8  signed Q sample.
- out_valid  out  1  dataI/dataQ carry a live symbol sample.
- sym_start  out  1  first sample of a symbol.
- dibit_out  out  2  {I bit, Q bit} of the symbol currently on the outputs.
- underrun  out  1  sticky; set when a symbol ends with no pending dibit.

Behaviour:
- Reset values: dataI=0, dataQ=0, out_valid=0, sym_start=0, dibit_out=0, underrun=0, bit_ready=1. Assembler empty, pending empty, state IDLE, sample count 0.
- Transfer rule: a bit transfers on any cycle with bit_valid && bit_ready.
- bit_ready = !pending_full (registered flag).
- Assembler:
  - First accepted bit is held as the I bit.
  - Second accepted bit forms dibit {I,Q}, loads the pending register and sets pending_full on the same edge.
- States:
  - IDLE: outputs 0, out_valid=0. When pending_full, load the symbol and go to PLAY.
  - PLAY: counter runs 0..SPS-1.
  - At SPS-1 with pending_full: load the next symbol back-to-back, with no gap.
  - At SPS-1 with pending empty: set underrun, go to IDLE, zero the outputs on the next cycle.
- Symbol load:
  - Registers dataI/dataQ/dibit_out and clears pending_full.
  - Sets sym_start=1 for that one sample, out_valid=1, counter=0.
- Latency: the first sample appears on the cycle after the edge that captured the second bit into pending.
  - Example: bits accepted at cycles 0 and 1 give out_valid=1 at cycle 3.
- Mapping: bit 0 gives +AMP, bit 1 gives -AMP, independently on I and Q (Gray QPSK).
- No overlap hazard: pending consumption and pending fill never coincide, because bit_ready=0 while pending_full.
- Throughput: a stream of one bit per clock never underruns for SPS>=2.
- Stall: bit_valid low mid-pair keeps the half-dibit indefinitely.
- Underrun: cleared only by rst.
- rst mid-symbol: everything returns to reset values on the next edge and the half-assembled dibit is discarded.

Optional Feature:
- Macro: QPSK_DIFF_EN.
- When defined:
  - Differential encoding. The dibit is a phase increment: 00→0, 01→+1, 11→+2, 10→+3 quadrants.
  - Accumulated into a 2-bit phase register; reset 0, updated at symbol load.
  - Phase maps to levels: 0→(+,+), 1→(-,+), 2→(-,-), 3→(+,-).
  - dibit_out still reports the raw input dibit.
- When undefined: direct mapping as above; no phase register is synthesised.

Decomposition:
- Shared package qpsk_pkg:
  - Default AMP.
  - dibit typedef (2-bit).
  - Phase/dibit Gray lookup constants, shared with the decoder's slicer.
- One natural sub-module, qpsk_level_map: combinational dibit (or phase) to signed I/Q levels, reused by the decoder reference model.

Test Plan:
- Reset then bits 0,1 at consecutive cycles with SPS=8, AMP=90:
  - Outputs: dataI=90, dataQ=-90 for 8 cycles, sym_start on the first only, dibit_out=2'b01.
  - Then underrun=1 and out_valid=0.
- Continuous valid bit stream 00,11,10,01:
  - Four back-to-back symbols, (+90,+90),(-90,-90),(-90,+90),(+90,-90).
  - No out_valid gap.
  - bit_ready low from pending fill until symbol load.
- Single bit 1, then bit_valid low for 20 cycles, then bit 0:
  - No output during the gap.
  - Symbol (-90,+90) starts 2 cycles after the second bit is accepted.
- rst asserted at sample 3 of a symbol, with a half-dibit held:
  - All outputs 0 next cycle, underrun=0.
  - Next pair 0,0 produces a fresh symbol (+90,+90).
- QPSK_DIFF_EN, dibits 01,01,01,01 from reset:
  - Phases 1,2,3,0.
  - Levels (-90,+90),(-90,-90),(+90,-90),(+90,+90).
- SPS=2 with a bit every cycle for 1000 cycles: underrun stays 0 and out_valid stays 1 after the first symbol.
